// File: rtl/llr_if.sv
// llr_if: handshake and data bundle between the LLR stage and its
// alpha/beta/gamma memories and downstream consumer.
// a[s] = alpha_k(s), b[s] = beta_k+1(s), g[x][bit] = gamma of the branch
// into next state x with input bit 'bit'.
interface llr_if #(
    parameter int ADDR_W = 8,
    parameter int LLR_W  = 16
);
    logic                     start;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [15:0]       a [8];
    logic signed [15:0]       b [8];
    logic signed [15:0]       g [8][2];
    logic signed [LLR_W-1:0]  llr;
    logic                     llr_valid;
    logic                     hard_bit;
    logic [ADDR_W-1:0]        llr_idx;
    logic                     busy;
    logic                     done;

    modport master (
        output start, a, b, g,
        input  rd_en, rd_addr, llr, llr_valid, hard_bit, llr_idx, busy, done
    );

    modport slave (
        input  start, a, b, g,
        output rd_en, rd_addr, llr, llr_valid, hard_bit, llr_idx, busy, done
    );
endinterface

// File: rtl/llr_stage.sv
// llr_stage: final max-log-MAP stage. Sweeps k = 0..FRAME_LEN-1 over the
// alpha/beta/gamma memories and emits one saturated LLR and hard decision
// per cycle, 6 cycles after the read strobe of the same index.
// Optional build macro LLR_SCALE_EN: output is diff - (diff >>> 2) before
// saturation (about 0.75 extrinsic scaling), same latency.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing read addresses 0..FRAME_LEN-1
// DRAIN | waiting for the last LLR to leave the pipeline
module llr_stage #(
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 8,
    parameter int LLR_W     = 16
) (
    input  logic clk,
    input  logic rst,
    llr_if.slave io
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [ADDR_W-1:0]  LAST   = ADDR_W'(FRAME_LEN - 1);
    localparam logic signed [18:0] SAT_HI = (19'sd1 <<< (LLR_W - 1)) - 19'sd1;
    localparam logic signed [18:0] SAT_LO = -(19'sd1 <<< (LLR_W - 1));
    // Next trellis state reached from current state s with input bit 0 / 1
    localparam logic [2:0] NXT0 [8] = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd2, 3'd6, 3'd7, 3'd3};
    localparam logic [2:0] NXT1 [8] = '{3'd4, 3'd0, 3'd1, 3'd5, 3'd6, 3'd2, 3'd3, 3'd7};

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [5:0]              vld_q;
    logic [ADDR_W-1:0]       idx_q [6];
    logic signed [17:0]      sum_q [2][8];
    logic signed [17:0]      mx4_q [2][4];
    logic signed [17:0]      mx2_q [2][2];
    logic signed [17:0]      mx1_q [2];
    logic signed [LLR_W-1:0] llr_q;
    logic                    hard_q;
    logic signed [18:0]      diff_w, scl_w, sat_w;
    logic                    rd_en_w, done_w;

    function automatic logic signed [17:0] sx(input logic signed [15:0] v);
        return 18'(v);
    endfunction

    function automatic logic signed [17:0] smax(input logic signed [17:0] x,
                                                input logic signed [17:0] y);
        return (x > y) ? x : y;
    endfunction

    assign rd_en_w = (state_q == READ);
    assign done_w  = (state_q == DRAIN) && vld_q[5] && (idx_q[5] == LAST);

    assign io.rd_en     = rd_en_w;
    assign io.rd_addr   = addr_q;
    assign io.busy      = (state_q != IDLE);
    assign io.done      = done_w;
    assign io.llr       = llr_q;
    assign io.llr_valid = vld_q[5];
    assign io.hard_bit  = hard_q;
    assign io.llr_idx   = idx_q[5];

    // FSM state and read address registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state and read address sequencing; start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_d = READ;
                    addr_d  = '0;
                end
            end
            READ: begin
                if (addr_q == LAST) state_d = DRAIN;
                else                addr_d  = addr_q + 1'b1;
            end
            DRAIN: begin
                if (done_w) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Valid/index shadow pipeline; indices only move with valid data so
    // llr_idx holds its last value between frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int j = 0; j < 6; j++) idx_q[j] <= '0;
        end else begin
            vld_q <= {vld_q[4:0], rd_en_w};
            if (rd_en_w) idx_q[0] <= addr_q;
            for (int j = 1; j < 6; j++) begin
                if (vld_q[j-1]) idx_q[j] <= idx_q[j-1];
            end
        end
    end

    // P5 arithmetic: bit1 minus bit0 metric, optional scaling, saturation
    always_comb begin
        diff_w = {mx1_q[1][17], mx1_q[1]} - {mx1_q[0][17], mx1_q[0]};
`ifdef LLR_SCALE_EN
        scl_w = diff_w - (diff_w >>> 2);
`else
        scl_w = diff_w;
`endif
        if (scl_w > SAT_HI)      sat_w = SAT_HI;
        else if (scl_w < SAT_LO) sat_w = SAT_LO;
        else                     sat_w = scl_w;
    end

    // Datapath: P1 branch sums, P2-P4 max trees, P5 saturated LLR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < 2; t++) begin
                for (int s = 0; s < 8; s++) sum_q[t][s] <= '0;
                for (int j = 0; j < 4; j++) mx4_q[t][j] <= '0;
                for (int j = 0; j < 2; j++) mx2_q[t][j] <= '0;
                mx1_q[t] <= '0;
            end
            llr_q  <= '0;
            hard_q <= 1'b0;
        end else begin
            for (int s = 0; s < 8; s++) begin
                sum_q[0][s] <= sx(io.a[s]) + sx(io.g[NXT0[s]][0]) + sx(io.b[NXT0[s]]);
                sum_q[1][s] <= sx(io.a[s]) + sx(io.g[NXT1[s]][1]) + sx(io.b[NXT1[s]]);
            end
            for (int t = 0; t < 2; t++) begin
                for (int j = 0; j < 4; j++) mx4_q[t][j] <= smax(sum_q[t][2*j], sum_q[t][2*j+1]);
                for (int j = 0; j < 2; j++) mx2_q[t][j] <= smax(mx4_q[t][2*j], mx4_q[t][2*j+1]);
                mx1_q[t] <= smax(mx2_q[t][0], mx2_q[t][1]);
            end
            if (vld_q[4]) begin
                llr_q  <= sat_w[LLR_W-1:0];
                hard_q <= (sat_w > 19'sd0);
            end
        end
    end
endmodule
